// File: rtl/ingress_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the header-parser AXI-Stream input.
// Holds a grant until tlast is accepted; keeps per-port packet counts and a sticky stall flag.

package hdu_pkg;
  parameter int DATA_WIDTH = 64;
endpackage

module ingress_stream_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = hdu_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_LIMIT = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_port,
  output logic                            busy,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count,
  output logic                            stall_err,
  input  logic                            clr_stats
);

  localparam int GW  = $clog2(NUM_PORTS);
  localparam int SCW = $clog2(STALL_LIMIT + 1);
  localparam logic [GW:0]    NP        = (GW+1)'(NUM_PORTS);
  localparam logic [SCW-1:0] STALL_MAX = SCW'(STALL_LIMIT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  last_grant_q, last_grant_d;
  logic [GW-1:0]  grant_port_q, grant_port_d;
  logic           busy_q, busy_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           stall_err_q, stall_err_d;

  logic [GW-1:0]  sel_port;
  logic           sel_valid;
  logic [GW:0]    idx;
  logic           gnt_valid;
  logic           gnt_last;
  logic           accept;
  logic           accept_last;

  assign gnt_valid   = s_axis_tvalid[grant_port_q];
  assign gnt_last    = s_axis_tlast[grant_port_q];
  assign accept      = (state_q == LOCKED) && !rst && gnt_valid && m_axis_tready;
  assign accept_last = accept && gnt_last;

  // Descending scan so the port closest after last_grant overwrites the others.
  always_comb begin
    sel_port  = '0;
    sel_valid = 1'b0;
    idx       = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = {1'b0, last_grant_q} + (GW+1)'(i);
      if (idx >= NP) begin
        idx = idx - NP;
      end
      if (s_axis_tvalid[idx[GW-1:0]]) begin
        sel_port  = idx[GW-1:0];
        sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_PORTS - 1);
      grant_port_q <= '0;
      busy_q       <= 1'b0;
      stall_cnt_q  <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_port_q <= grant_port_d;
      busy_q       <= busy_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_port_d = grant_port_q;
    busy_d       = busy_q;
    stall_cnt_d  = stall_cnt_q;
    stall_err_d  = stall_err_q;
    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (sel_valid) begin
          grant_port_d = sel_port;
          busy_d       = 1'b1;
          state_d      = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) begin
          stall_cnt_d = '0;
        end else if (!gnt_valid && stall_cnt_q != STALL_MAX) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (accept_last) begin
          last_grant_d = grant_port_q;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flag sets on the transition into saturation, so a clear is not undone by a lingering stall.
    if (stall_cnt_d == STALL_MAX && stall_cnt_q != STALL_MAX) begin
      stall_err_d = 1'b1;
    end
    if (clr_stats) begin
      stall_err_d = 1'b0;
    end
  end

  always_comb begin
    m_axis_tdata  = s_axis_tdata[grant_port_q*DATA_WIDTH +: DATA_WIDTH];
    m_axis_tlast  = gnt_last;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == LOCKED && !rst) begin
      m_axis_tvalid               = gnt_valid;
      s_axis_tready[grant_port_q] = m_axis_tready;
    end
  end

  assign grant_port = grant_port_q;
  assign busy       = busy_q;
  assign stall_err  = stall_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_stats) begin
          cnt_d = '0;
        end else if (accept_last && grant_port_q == GW'(gi)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_ingress_stream_arbiter.sv
// Directed bench for ingress_stream_arbiter: per-port source queues, expected-beat scoreboard.
module tb_ingress_stream_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int SL = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP*DW-1:0]  s_axis_tdata = '0;
  logic [NP-1:0]     s_axis_tlast = '0;
  logic [NP-1:0]     s_axis_tvalid = '0;
  logic [NP-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [1:0]        grant_port;
  logic              busy;
  logic [NP*CW-1:0]  pkt_count;
  logic              stall_err;
  logic              clr_stats = 1'b0;

  ingress_stream_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .grant_port(grant_port), .busy(busy), .pkt_count(pkt_count),
    .stall_err(stall_err), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    port;
  } beat_t;

  beat_t    src_q [NP][$];
  beat_t    exp_q [$];
  logic [NP-1:0] stall_mask = '0;
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int p, input int len, input int tag, input bit do_exp);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = {8'(p), 8'(tag), 16'(b)};
      bt.last = (b == len - 1);
      bt.port = 2'(p);
      src_q[p].push_back(bt);
      if (do_exp) exp_q.push_back(bt);
    end
  endtask

  task automatic refresh();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0 && !stall_mask[p]) begin
        s_axis_tvalid[p]          = 1'b1;
        s_axis_tdata[p*DW +: DW]  = src_q[p][0].data;
        s_axis_tlast[p]           = src_q[p][0].last;
      end else begin
        s_axis_tvalid[p] = 1'b0;
        s_axis_tlast[p]  = 1'b0;
      end
    end
  endtask

  // Observe handshakes mid-cycle, then advance the sources just after the edge.
  task automatic tick();
    logic [NP-1:0] fire;
    beat_t e;
    @(negedge clk);
    fire = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(m_axis_tdata), 64'hdead);
      end else begin
        e = exp_q.pop_front();
        $display("beat port=%0d data=%h last=%0d", grant_port, m_axis_tdata, m_axis_tlast);
        chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
        chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
        chk("beat_port", 64'(grant_port), 64'(e.port));
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (fire[p]) e = src_q[p].pop_front();
    end
    refresh();
  endtask

  task automatic drain(input int budget, output int cnt);
    cnt = 0;
    while (exp_q.size() > 0 && cnt < budget) begin
      tick();
      cnt++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all four ports already presenting packets
    for (int p = 0; p < NP; p++) add_pkt(p, 3, 1, 1);
    refresh();
    tick();
    tick();
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    rst = 1'b0;
    chk("post_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("post_rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_grant", 64'(grant_port), 64'd0);
    chk("post_rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("post_rst_stall_err", 64'(stall_err), 64'd0);

    // Round robin 0,1,2,3 with one arbitration cycle per packet
    drain(100, n);
    chk("rr_cycles", 64'(n), 64'd16);
    chk("rr_pkt_count", 64'(pkt_count), 64'h01010101);

    // Port 1 backlogged; port 2 arrives mid-packet and must not interrupt
    add_pkt(1, 4, 2, 1);
    refresh();
    tick();
    tick();
    tick();
    add_pkt(2, 2, 3, 1);
    add_pkt(1, 4, 4, 1);
    refresh();
    chk("lock_grant", 64'(grant_port), 64'd1);
    drain(100, n);
    chk("lock_cycles", 64'(n), 64'd10);
    chk("lock_pkt_count", 64'(pkt_count), 64'h01020301);

    // Upstream stall of 300 cycles mid-packet on port 0, port 1 waiting
    add_pkt(0, 4, 5, 1);
    add_pkt(1, 2, 6, 1);
    refresh();
    tick();
    tick();
    stall_mask[0] = 1'b1;
    refresh();
    repeat (SL - 1) tick();
    chk("stall_before_limit", 64'(stall_err), 64'd0);
    tick();
    chk("stall_at_limit", 64'(stall_err), 64'd1);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_grant", 64'(grant_port), 64'd0);
    chk("stall_others_blocked", 64'(s_axis_tready[1]), 64'd0);
    repeat (300 - SL) tick();
    chk("stall_sticky", 64'(stall_err), 64'd1);
    chk("stall_grant_held", 64'(grant_port), 64'd0);
    stall_mask[0] = 1'b0;
    refresh();
    drain(100, n);
    chk("stall_pkt_count", 64'(pkt_count), 64'h01020402);
    chk("stall_err_kept", 64'(stall_err), 64'd1);

    // Clear, then 500 cycles of downstream backpressure
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_stall_err", 64'(stall_err), 64'd0);
    chk("clr_pkt_count", 64'(pkt_count), 64'd0);
    add_pkt(2, 2, 7, 1);
    m_axis_tready = 1'b0;
    refresh();
    repeat (500) tick();
    chk("bp_stall_err", 64'(stall_err), 64'd0);
    chk("bp_s_tready", 64'(s_axis_tready), 64'd0);
    chk("bp_m_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("bp_grant", 64'(grant_port), 64'd2);
    chk("bp_no_loss", 64'(exp_q.size()), 64'd2);
    m_axis_tready = 1'b1;
    drain(100, n);
    chk("bp_pkt_count", 64'(pkt_count), 64'h00010000);

    // Clear coincident with tlast acceptance at pkt_count[0]=5
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    for (int k = 0; k < 5; k++) add_pkt(0, 1, 8 + k, 1);
    refresh();
    drain(100, n);
    chk("single_cycles", 64'(n), 64'd10);
    chk("five_pkts", 64'(pkt_count[7:0]), 64'd5);
    add_pkt(0, 2, 20, 1);
    refresh();
    tick();
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_wins", 64'(pkt_count[7:0]), 64'd0);
    chk("clr_tlast_seen", 64'(exp_q.size()), 64'd0);
    tick();
    chk("clr_event_lost", 64'(pkt_count[7:0]), 64'd0);
    chk("clr_idle", 64'(busy), 64'd0);

    // Counter wrap on port 3
    for (int k = 0; k < (1 << CW) - 1; k++) add_pkt(3, 1, k, 1);
    refresh();
    drain(2000, n);
    chk("wrap_max", 64'(pkt_count[31:24]), 64'd255);
    add_pkt(3, 1, 99, 1);
    refresh();
    drain(100, n);
    chk("wrap_zero", 64'(pkt_count[31:24]), 64'd0);

    // Reset on the second beat of a 4-beat packet
    add_pkt(1, 4, 30, 1);
    refresh();
    tick();
    tick();
    chk("pre_rst_grant", 64'(grant_port), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
    chk("midrst_grant", 64'(grant_port), 64'd0);
    chk("midrst_stall_err", 64'(stall_err), 64'd0);
    chk("midrst_remaining", 64'(exp_q.size()), 64'd3);
    drain(100, n);
    chk("midrst_cycles", 64'(n), 64'd4);
    chk("midrst_new_pkt", 64'(pkt_count[15:8]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ingress_stream_arbiter.md
Name: ingress_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single header-parser AXI-Stream input among NUM_PORTS ingress streams (e.g. per-NIC-queue or per-tenant invocation streams).
- Once a port is granted, it holds the grant until its tlast beat is accepted, so header/payload beats of different packets never interleave.
- Maintains per-port packet counters and a sticky mid-packet upstream-stall flag for the control plane.

Parameters:
- NUM_PORTS, 4, number of ingress streams (2..16)
- DATA_WIDTH, hdu_pkg::DATA_WIDTH, beat width, identical to the header parser input
- CNT_WIDTH, 16, width of each per-port packet counter
- STALL_LIMIT, 256, consecutive upstream-idle cycles inside a granted packet before stall_err sets (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  ingress data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tlast  in  NUM_PORTS  per-port last beat
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready
- m_axis_tdata  out  DATA_WIDTH  to header parser
- m_axis_tlast  out  1  to header parser
- m_axis_tvalid  out  1  to header parser
- m_axis_tready  in  1  from header parser
- grant_port  out  $clog2(NUM_PORTS)  currently or last granted port
- busy  out  1  high while a packet is locked
- pkt_count  out  NUM_PORTS*CNT_WIDTH  completed packets per port, port i at [i*CNT_WIDTH +: CNT_WIDTH]
- stall_err  out  1  sticky upstream-stall flag
- clr_stats  in  1  clears pkt_count and stall_err

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, last_grant=NUM_PORTS-1 (port 0 has first priority), grant_port=0, busy=0, pkt_count all 0, stall_err=0, stall counter=0.
- Outputs during and immediately after reset: m_axis_tvalid=0, all s_axis_tready=0.
- FSM states: IDLE, LOCKED.
- IDLE:
  - m_axis_tvalid=0; m_axis_tdata/tlast = port grant_port values (don't-care); all s_axis_tready=0.
  - If any s_axis_tvalid is high, select the first port with tvalid high, searching from last_grant+1 upward modulo NUM_PORTS.
  - Register the selection into grant_port, set busy=1, move to LOCKED. Arbitration costs exactly 1 cycle.
  - If no tvalid is high, stay in IDLE.
- LOCKED (combinational datapath, 0-cycle latency):
  - m_axis_tdata/tlast/tvalid = port grant_port.
  - s_axis_tready[grant_port] = m_axis_tready; all other tready=0.
  - A beat is accepted when m_axis_tvalid && m_axis_tready.
  - When the accepted beat has tlast=1: increment pkt_count[grant_port] (wraps modulo 2^CNT_WIDTH), set last_grant<=grant_port, busy<=0, state<=IDLE.
  - Packet-to-packet gap is therefore ≥1 cycle.
  - Grant never changes mid-packet, regardless of other ports' tvalid.
- Stall detection (LOCKED only):
  - Counter increments each cycle s_axis_tvalid[grant_port]=0.
  - Counter clears on any accepted beat and on entry to IDLE.
  - Downstream backpressure (tvalid=1, tready=0) does not count.
  - When the counter reaches STALL_LIMIT, set stall_err=1 and saturate the counter. The packet is not aborted and the grant is held.
- clr_stats: next cycle pkt_count=0 and stall_err=0.
  - Clear has priority over a coincident increment or set; that event is lost.
- Single-beat packet (tlast on first beat): LOCKED for one cycle if m_axis_tready=1, then IDLE.
- A port whose tvalid drops while in IDLE before being granted is simply not selected. Protocol requires AXI tvalid to stay high, so this is not an error.
- Reset mid-packet: immediate return to IDLE. The remainder of the truncated packet is treated as a new packet by the next grant. Upstream and downstream must reset together.
- grant_port holds its last value in IDLE until the next arbitration.

Test Plan:
- Ports 0–3 each present one 3-beat packet simultaneously after reset, m_axis_tready=1 -> output order 0,1,2,3; packets contiguous, 1 idle cycle between; pkt_count = 1,1,1,1.
- Port 1 continuously backlogged, port 2 presents a packet mid-way through port 1's 4-beat packet -> port 1 completes all 4 beats uninterrupted; next grant goes to port 2, then back to port 1.
- Granted port 0 drops tvalid for 300 cycles mid-packet, STALL_LIMIT=256 -> stall_err=1 from cycle 256 onward; grant held; packet completes when tvalid returns; others blocked.
- m_axis_tready held 0 for 500 cycles with granted tvalid=1 -> stall_err stays 0, no data loss, s_axis_tready[grant]=0.
- Drive clr_stats in the same cycle as a tlast acceptance with pkt_count[0]=5 -> pkt_count[0]=0 next cycle; 2^16 single-beat packets on port 3 -> pkt_count[3] wraps to 0.
- Assert rst on the 2nd beat of a 4-beat packet -> next cycle state IDLE, busy=0, all tready=0, counters 0, grant_port=0.
